// File: rtl/feature_stream_tx.sv
// feature_stream_tx: serializes multi-channel pixels into a framed, channel-per-cycle sample stream
//   clk, reset_n                     : rising-edge clock, asynchronous active-low reset
//   start_i                          : arms one frame; ignored unless idle
//   pix_valid_i, pix_data_i          : pixel input, channel 0 in the LSBs
//   pix_ready_o                      : pixel accepted when valid and ready meet on a clock edge
//   data_o, valid_o                  : one registered channel sample per cycle
//   sop_o/eop_o, sof_o/eof_o         : line start/end and frame start/end qualifiers
//   busy_o                           : a frame is armed or in progress
module feature_stream_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 3,
  parameter int STRING_LEN  = 224,
  parameter int STRING_NUM  = 224,
  parameter int GAP         = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start_i,
  input  logic                                pix_valid_i,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0]   pix_data_i,
  output logic                                pix_ready_o,
  output logic signed [DATA_WIDTH-1:0]        data_o,
  output logic                                valid_o,
  output logic                                sop_o,
  output logic                                eop_o,
  output logic                                sof_o,
  output logic                                eof_o,
  output logic                                busy_o
);
  localparam int CW = $clog2(CHANNEL_NUM) + 1;
  localparam int XW = $clog2(STRING_LEN) + 1;
  localparam int YW = $clog2(STRING_NUM) + 1;
  localparam int GW = $clog2(GAP) + 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNEL_NUM - 1);
  localparam logic [XW-1:0] COL_LAST = XW'(STRING_LEN - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(STRING_NUM - 1);
  // HOLD lasts the full GAP at frame end; mid-frame the following LOAD cycle
  // is itself one of the idle cycles, so HOLD is one cycle shorter there.
  localparam logic [GW-1:0] HOLD_END = GW'(GAP - 1);
  localparam logic [GW-1:0] HOLD_MID = GW'(GAP - 2);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, HOLD = 2'd3;
  logic [1:0]                          state_q, state_d;
  logic [CW-1:0]                       ch_q;
  logic [XW-1:0]                       col_q;
  logic [YW-1:0]                       row_q;
  logic [GW-1:0]                       gap_q;
  logic [CHANNEL_NUM*DATA_WIDTH-1:0]   sh_q;
  logic signed [DATA_WIDTH-1:0]        data_q;
  logic                                lcol_q, lrow_q;
  logic                                valid_q, sop_q, eop_q, sof_q, eof_q;
  logic                                last_ch, last_pix, next_ch, hold_done, accept;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;
  assign busy_o  = state_q != IDLE;
  always_comb begin
    last_ch     = state_q == SEND && ch_q == CH_LAST;
    last_pix    = lcol_q && lrow_q;
    next_ch     = state_q == SEND && !last_ch;
    hold_done   = gap_q == (last_pix ? HOLD_END : HOLD_MID);
    pix_ready_o = state_q == LOAD || (GAP == 0 && last_ch && !last_pix);
    accept      = pix_valid_i && pix_ready_o;
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? LOAD : IDLE;
      LOAD:    state_d = accept ? SEND : LOAD;
      SEND:    state_d = !last_ch || accept ? SEND :
                         last_pix ? (GAP > 0 ? HOLD : IDLE) :
                         GAP > 1 ? HOLD : LOAD;
      default: state_d = !hold_done ? HOLD : last_pix ? IDLE : LOAD;
    endcase
  end
  // col_q/row_q hold the position of the next pixel to be accepted; the
  // end-of-line/frame flags of the pixel in flight are latched at accept.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      {lcol_q, lrow_q} <= '0;
      {valid_q, sop_q, eop_q, sof_q, eof_q} <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= state_q == HOLD ? gap_q + 1'b1 : '0;
      valid_q <= accept || next_ch;
      if (state_q == IDLE && start_i) begin
        col_q <= '0;
        row_q <= '0;
      end
      if (accept) begin
        col_q  <= col_q == COL_LAST ? '0 : col_q + 1'b1;
        row_q  <= col_q == COL_LAST ? row_q + 1'b1 : row_q;
        lcol_q <= col_q == COL_LAST;
        lrow_q <= row_q == ROW_LAST;
        ch_q   <= '0;
        sh_q   <= pix_data_i >> DATA_WIDTH;
        data_q <= pix_data_i[DATA_WIDTH-1:0];
        sop_q  <= col_q == '0;
        sof_q  <= col_q == '0 && row_q == '0;
        eop_q  <= CHANNEL_NUM == 1 && col_q == COL_LAST;
        eof_q  <= CHANNEL_NUM == 1 && col_q == COL_LAST && row_q == ROW_LAST;
      end else if (next_ch) begin
        ch_q   <= ch_q + 1'b1;
        sh_q   <= sh_q >> DATA_WIDTH;
        data_q <= sh_q[DATA_WIDTH-1:0];
        sop_q  <= 1'b0;
        sof_q  <= 1'b0;
        eop_q  <= ch_q + 1'b1 == CH_LAST && lcol_q;
        eof_q  <= ch_q + 1'b1 == CH_LAST && lcol_q && lrow_q;
      end else
        {sop_q, eop_q, sof_q, eof_q} <= '0;
    end
endmodule

// File: doc/feature_stream_tx.md
FEATURE_STREAM_TX -- requirements
Module: feature_stream_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one channel sample.
REQ-002 SHALL have parameter CHANNEL_NUM, default 3: channels per pixel, emitted serially.
REQ-003 SHALL have parameter STRING_LEN, default 224: pixels per line.
REQ-004 SHALL have parameter STRING_NUM, default 224: lines per frame.
REQ-005 SHALL have parameter GAP, default 0: idle cycles inserted after each pixel's channel burst.
REQ-006 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start_i, input, 1: arms transmission of one frame.
REQ-009 SHALL have port pix_valid_i, input, 1: pix_data_i holds a pixel.
REQ-010 SHALL have port pix_data_i, input, CHANNEL_NUM*DATA_WIDTH: pixel, channel 0 in the LSBs.
REQ-011 SHALL have port pix_ready_o, output, 1: pixel accepted when pix_valid_i and pix_ready_o are both high on a clk edge.
REQ-012 SHALL have port data_o, output, signed DATA_WIDTH: serialized channel sample.
REQ-013 SHALL have ports valid_o, sop_o, eop_o, sof_o, eof_o, output, 1 each: stream qualifiers.
REQ-014 SHALL have port busy_o, output, 1: a frame is armed or in progress.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, SEND and HOLD.
REQ-016 IDLE: start_i=1 SHALL move to LOAD, clear the col and row counters and set busy_o; start_i in any other state SHALL be ignored.
REQ-017 LOAD: pix_ready_o=1; on accept, SHALL latch pix_data_i into a shift register, clear ch_cnt and go to SEND.
REQ-018 SEND: SHALL drive registered data_o = channel ch_cnt with valid_o=1 for exactly CHANNEL_NUM consecutive cycles, channel 0 first.
REQ-019 Latency from accept edge to first valid_o SHALL be 1 cycle.
REQ-020 valid_o SHALL stay high through all CHANNEL_NUM cycles of a pixel; there is no downstream backpressure.
REQ-021 After the last channel: GAP>0 SHALL go to HOLD for exactly GAP cycles with valid_o=0; GAP=0 SHALL bypass HOLD.
REQ-022 GAP=0 only: during the last-channel cycle pix_ready_o SHALL be asserted so the next pixel streams back-to-back with no bubble; if no pixel is accepted, the FSM SHALL go to LOAD.
REQ-023 The next-pixel accept SHALL NOT be offered on the last pixel of the frame.
REQ-024 sop_o SHALL be 1 with the channel-0 word of col 0.
REQ-025 eop_o SHALL be 1 with the channel CHANNEL_NUM-1 word of col STRING_LEN-1.
REQ-026 sof_o SHALL equal sop_o on row 0; eof_o SHALL equal eop_o on row STRING_NUM-1.
REQ-027 When CHANNEL_NUM=1 and STRING_LEN=1, sop_o, eop_o, sof_o and eof_o SHALL coexist on one word.
REQ-028 col_cnt SHALL wrap from STRING_LEN-1 to 0 and then increment row_cnt.
REQ-029 After the eof_o word (and any GAP), the FSM SHALL return to IDLE and drop busy_o the following cycle.
REQ-030 A start_i coincident with that IDLE entry SHALL be ignored.
REQ-031 Outside valid_o=1, data_o SHALL hold its last value and all qualifiers SHALL be 0.
REQ-032 pix_ready_o SHALL be 0 in IDLE and HOLD.
REQ-033 Counter widths SHALL be $clog2 of their terminal value plus 1, to avoid overflow at boundaries.

Reset
REQ-034 reset_n=0 SHALL asynchronously force FSM=IDLE, all counters=0, data_o=0, and valid_o, sop_o, eop_o, sof_o, eof_o, pix_ready_o, busy_o=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame: no further words are emitted and the partial frame is not resumed.
REQ-036 After reset release, the block SHALL wait for a new start_i.

Verification (CHANNEL_NUM=3, STRING_LEN=4, STRING_NUM=2, DATA_WIDTH=8 unless noted)
REQ-037 Scenario, GAP=0, pix_valid_i held 1: start, then pixels 0x030201, 0x060504, ... -> data_o = 01,02,03,04,05,06,... as 24 contiguous valid words; sop_o at words 0 and 12; eop_o at words 11 and 23; sof_o at word 0 only; eof_o at word 23 only; busy_o falls 1 cycle after word 23.
REQ-038 Scenario, GAP=2: same stimulus -> exactly 2 idle cycles after every 3-word burst, and 2 idle cycles after word 23 before IDLE.
REQ-039 Scenario, pix_valid_i toggling 1-0-1 randomly, GAP=0 -> word order and qualifier positions identical to REQ-037; no pixel duplicated or dropped; pix_ready_o never high in IDLE.
REQ-040 Scenario, reset_n pulsed low at word 7 -> all outputs 0 asynchronously; start_i after release -> fresh frame starting with sof_o and data_o = channel 0 of the first new pixel.
REQ-041 Scenario, start_i pulsed during SEND and again on the eof_o cycle -> both ignored; exactly one frame emitted.
REQ-042 Scenario, CHANNEL_NUM=1, STRING_LEN=1, STRING_NUM=1 -> a single word with valid_o, sop_o, eop_o, sof_o and eof_o all 1.
